// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: opcode map, control FSM state encoding and alu_op codes.
// Used by the multicycle controller and the single-cycle Control_Unit.
package risc16_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_LW        = 4'h0;
  localparam logic [3:0] OP_SW        = 4'h1;
  localparam logic [3:0] OP_ALU_FIRST = 4'h2;
  localparam logic [3:0] OP_ALU_LAST  = 4'h9;
  localparam logic [3:0] OP_BEQ       = 4'hB;
  localparam logic [3:0] OP_BNE       = 4'hC;
  localparam logic [3:0] OP_J         = 4'hD;
  localparam logic [3:0] OP_HALT      = 4'hF;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == 4'hA) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC16 control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory handshake,
// illegal-opcode pulse and a wrapping retired-instruction counter.
module multicycle_ctrl
  import risc16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg_write,
  output logic        beq,
  output logic        bne,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        retired,
  output logic [15:0] retire_cnt
);

  state_e      state_r;
  state_e      state_next_s;
  logic [3:0]  op_r;
  logic [15:0] retire_cnt_r;

  // State register and opcode capture; op_r is the only opcode source after DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      op_r    <= 4'h0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_DECODE) begin
        op_r <= opcode;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Next-state and control decode; everything is forced low while reset is held.
  always_comb begin
    state_next_s = state_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    beq          = 1'b0;
    bne          = 1'b0;
    jump         = 1'b0;
    alu_op       = ALUOP_ADD;
    illegal      = 1'b0;
    retired      = 1'b0;
    if (rst_n) begin
      case (state_r)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            state_next_s = ST_DECODE;
          end else begin
            state_next_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (opcode == OP_HALT) begin
            state_next_s = ST_HALT;
          end else if (is_illegal_op(opcode)) begin
            illegal      = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_r)
            OP_LW, OP_SW: begin
              alu_op       = ALUOP_ADD;
              alu_src      = 1'b1;
              state_next_s = ST_MEM;
            end
            OP_BEQ: begin
              alu_op       = ALUOP_SUB;
              beq          = 1'b1;
              retired      = 1'b1;
              state_next_s = ST_FETCH;
            end
            OP_BNE: begin
              alu_op       = ALUOP_SUB;
              bne          = 1'b1;
              retired      = 1'b1;
              state_next_s = ST_FETCH;
            end
            OP_J: begin
              jump         = 1'b1;
              retired      = 1'b1;
              state_next_s = ST_FETCH;
            end
            default: begin
              if (is_alu_op(op_r)) begin
                alu_op       = ALUOP_FUNC;
                state_next_s = ST_WB;
              end else begin
                state_next_s = ST_FETCH;
              end
            end
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_r == OP_SW);
          if (mem_ready) begin
            if (op_r == OP_SW) begin
              retired      = 1'b1;
              state_next_s = ST_FETCH;
            end else begin
              state_next_s = ST_WB;
            end
          end else begin
            state_next_s = ST_MEM;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          retired   = 1'b1;
          if (op_r == OP_LW) begin
            mem_to_reg = 1'b1;
          end else begin
            reg_dst = 1'b1;
          end
          state_next_s = ST_FETCH;
        end
        ST_HALT: begin
          state_next_s = ST_HALT;
        end
        default: begin
          state_next_s = ST_FETCH;
        end
      endcase
    end else begin
      state_next_s = ST_FETCH;
    end
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_r <= 16'h0000;
    end else if (retired) begin
      retire_cnt_r <= retire_cnt_r + 16'h0001;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign state      = rst_n ? state_r : 3'd0;
  assign retire_cnt = rst_n ? retire_cnt_r : 16'h0000;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: each cycle's expected state/controls/count
// is queued when inputs are driven and checked on the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic        reg_dst, mem_to_reg, alu_src, reg_write, beq, bne, jump;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        illegal, retired;
  logic [15:0] retire_cnt;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] ctrl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'h0000;

  // ctrl bits: mem_req mem_we iord ir_write pc_write reg_dst mem_to_reg alu_src
  //            reg_write beq bne jump alu_op[1:0] illegal retired
  localparam logic [15:0] C_NONE      = 16'h0000;
  localparam logic [15:0] C_FETCH_W   = 16'h8000;
  localparam logic [15:0] C_FETCH_GO  = 16'h9800;
  localparam logic [15:0] C_ILLEGAL   = 16'h0002;
  localparam logic [15:0] C_EX_MEM    = 16'h0100;
  localparam logic [15:0] C_EX_ALU    = 16'h0008;
  localparam logic [15:0] C_EX_BEQ    = 16'h0045;
  localparam logic [15:0] C_EX_BNE    = 16'h0025;
  localparam logic [15:0] C_EX_J      = 16'h0011;
  localparam logic [15:0] C_MEM_LD    = 16'hA000;
  localparam logic [15:0] C_MEM_ST    = 16'hE000;
  localparam logic [15:0] C_MEM_ST_OK = 16'hE001;
  localparam logic [15:0] C_WB_LD     = 16'h0281;
  localparam logic [15:0] C_WB_ALU    = 16'h0481;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_write(reg_write), .beq(beq), .bne(bne), .jump(jump),
    .alu_op(alu_op), .state(state), .illegal(illegal), .retired(retired),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, queue the expectation, check at negedge, move past next posedge.
  task automatic cyc(input string tag, input logic rst, input logic rdy, input logic [3:0] opc,
                     input logic [2:0] es, input logic [15:0] ec);
    exp_t e;
    exp_t got;
    rst_n     = rst;
    mem_ready = rdy;
    opcode    = opc;
    e.st   = rst ? es : 3'd0;
    e.ctrl = rst ? ec : C_NONE;
    e.cnt  = rst ? exp_cnt : 16'h0000;
    sb_q.push_back(e);
    @(negedge clk);
    got.st   = state;
    got.ctrl = {mem_req, mem_we, iord, ir_write, pc_write, reg_dst, mem_to_reg, alu_src,
                reg_write, beq, bne, jump, alu_op, illegal, retired};
    got.cnt  = retire_cnt;
    e = sb_q.pop_front();
    n_checks++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed st=%0d ctrl=%h cnt=%h expected st=%0d ctrl=%h cnt=%h",
             tag, got.st, got.ctrl, got.cnt, e.st, e.ctrl, e.cnt);
    end
    if (!rst) exp_cnt = 16'h0000;
    else if (ec[0]) exp_cnt = exp_cnt + 16'h0001;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Full instruction with fetch and memory wait counts; opcode is scrambled after DECODE.
  task automatic instr(input string tag, input logic [3:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cyc({tag, "_fetchw"}, 1'b1, 1'b0, op, 3'd0, C_FETCH_W);
    cyc({tag, "_fetch"}, 1'b1, 1'b1, op, 3'd0, C_FETCH_GO);
    if (op == 4'hA || op == 4'hE) begin
      cyc({tag, "_dec_ill"}, 1'b1, rnd(), op, 3'd1, C_ILLEGAL);
      return;
    end
    cyc({tag, "_dec"}, 1'b1, rnd(), op, 3'd1, C_NONE);
    case (op)
      4'h0, 4'h1: begin
        cyc({tag, "_exec"}, 1'b1, rnd(), 4'hE, 3'd2, C_EX_MEM);
        for (int i = 0; i < mw; i++)
          cyc({tag, "_memw"}, 1'b1, 1'b0, 4'hE, 3'd3, (op == 4'h1) ? C_MEM_ST : C_MEM_LD);
        cyc({tag, "_mem"}, 1'b1, 1'b1, 4'hE, 3'd3, (op == 4'h1) ? C_MEM_ST_OK : C_MEM_LD);
        if (op == 4'h0) cyc({tag, "_wb"}, 1'b1, rnd(), 4'hE, 3'd4, C_WB_LD);
      end
      4'hB: cyc({tag, "_exec"}, 1'b1, rnd(), 4'hE, 3'd2, C_EX_BEQ);
      4'hC: cyc({tag, "_exec"}, 1'b1, rnd(), 4'hE, 3'd2, C_EX_BNE);
      4'hD: cyc({tag, "_exec"}, 1'b1, rnd(), 4'hE, 3'd2, C_EX_J);
      default: begin
        cyc({tag, "_exec"}, 1'b1, rnd(), 4'hE, 3'd2, C_EX_ALU);
        cyc({tag, "_wb"}, 1'b1, rnd(), 4'hE, 3'd4, C_WB_ALU);
      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 4'h0;
    cyc("reset0", 1'b0, 1'b1, 4'h1, 3'd0, C_NONE);
    cyc("reset1", 1'b0, 1'b1, 4'h1, 3'd0, C_NONE);

    instr("alu2", 4'h2, 0, 0);
    instr("lw", 4'h0, 0, 3);
    instr("sw", 4'h1, 1, 1);
    instr("beq", 4'hB, 0, 0);
    instr("bne", 4'hC, 2, 0);
    instr("j", 4'hD, 0, 0);
    instr("alu9", 4'h9, 0, 0);
    instr("ill_a", 4'hA, 0, 0);
    instr("ill_e", 4'hE, 1, 0);
    instr("lw0", 4'h0, 0, 0);

    // Counter wrap: preload the count register to its maximum, then retire one BEQ.
    dut.retire_cnt_r = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    instr("wrap_beq", 4'hB, 0, 0);
    cyc("wrap_after", 1'b1, 1'b0, 4'h0, 3'd0, C_FETCH_W);

    // SW aborted by reset while waiting in MEM.
    cyc("swr_fetch", 1'b1, 1'b1, 4'h1, 3'd0, C_FETCH_GO);
    cyc("swr_dec", 1'b1, 1'b0, 4'h1, 3'd1, C_NONE);
    cyc("swr_exec", 1'b1, 1'b1, 4'h1, 3'd2, C_EX_MEM);
    cyc("swr_memw", 1'b1, 1'b0, 4'h1, 3'd3, C_MEM_ST);
    cyc("swr_rst", 1'b0, 1'b1, 4'h1, 3'd0, C_NONE);
    cyc("swr_post", 1'b1, 1'b0, 4'h1, 3'd0, C_FETCH_W);

    // HALT holds regardless of mem_ready until reset.
    cyc("halt_fetch", 1'b1, 1'b1, 4'hF, 3'd0, C_FETCH_GO);
    cyc("halt_dec", 1'b1, 1'b1, 4'hF, 3'd1, C_NONE);
    for (int i = 0; i < 20; i++) cyc("halt_hold", 1'b1, rnd(), 4'h3, 3'd5, C_NONE);
    cyc("halt_rst", 1'b0, 1'b1, 4'h3, 3'd0, C_NONE);
    instr("alu_post", 4'h5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
